fm_discriminator: RTL

FM_DISCRIMINATOR -- requirements
Module: fm_discriminator

---
 rtl/fm_discriminator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fm_discriminator.sv
// FM quadrature discriminator: cross product d = I[n]*Q[n-1] - Q[n]*I[n-1]
// computed in full precision over a three-stage pipeline. The result is
// either emitted per sample (bypass=1) or summed over 2^LOG2_DEC products
// and dumped once per block (bypass=0).
module fm_discriminator #(
  parameter int DW = 8,
  parameter int LOG2_DEC = 2,
  localparam int OW = 2*DW + 1 + LOG2_DEC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] i_in,
  input  logic [DW-1:0] q_in,
  input  logic          bypass,
  output logic          out_valid,
  output logic [OW-1:0] m_out
);

  localparam int PW = 2*DW;
  localparam int DDW = 2*DW + 1;
  localparam int CW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_DEC) - 1);

  // Full-precision difference of the two products; one guard bit is enough.
  function automatic logic signed [DDW-1:0] cross_diff(
    input logic signed [PW-1:0] pa,
    input logic signed [PW-1:0] pb
  );
    logic signed [DDW-1:0] a;
    logic signed [DDW-1:0] b;
    a = pa;
    b = pb;
    return a - b;
  endfunction

  // Sign-extend a single product difference to the output/accumulator width.
  function automatic logic signed [OW-1:0] sext_d(input logic signed [DDW-1:0] d);
    logic signed [OW-1:0] r;
    r = d;
    return r;
  endfunction

  logic signed [DW-1:0]  r_hist_i;
  logic signed [DW-1:0]  r_hist_q;
  logic                  r_primed;

  logic signed [DW-1:0]  r_i_p0;
  logic signed [DW-1:0]  r_q_p0;
  logic signed [DW-1:0]  r_ip_p0;
  logic signed [DW-1:0]  r_qp_p0;
  logic                  r_vld_p0;

  logic signed [PW-1:0]  r_pa_p1;
  logic signed [PW-1:0]  r_pb_p1;
  logic                  r_vld_p1;

  logic signed [DDW-1:0] r_d_p2;
  logic                  r_vld_p2;

  logic signed [OW-1:0]  r_acc;
  logic [CW-1:0]         r_cnt;
  logic signed [OW-1:0]  r_dump_p3;
  logic                  r_dump_vld_p3;

  logic signed [OW-1:0]  r_m_out;
  logic                  r_out_valid;

  logic signed [PW-1:0]  w_pa;
  logic signed [PW-1:0]  w_pb;
  logic signed [OW-1:0]  w_d_ext;
  logic signed [OW-1:0]  w_sum;

  assign w_pa    = r_i_p0 * r_qp_p0;
  assign w_pb    = r_q_p0 * r_ip_p0;
  assign w_d_ext = sext_d(r_d_p2);
  assign w_sum   = r_acc + w_d_ext;

  assign m_out     = r_m_out;
  assign out_valid = r_out_valid;

  // Stage 1: capture sample with its predecessor; the first sample only primes history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist_i <= '0;
      r_hist_q <= '0;
      r_primed <= 1'b0;
      r_i_p0   <= '0;
      r_q_p0   <= '0;
      r_ip_p0  <= '0;
      r_qp_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= in_valid & r_primed;
      if (in_valid) begin
        r_i_p0   <= i_in;
        r_q_p0   <= q_in;
        r_ip_p0  <= r_hist_i;
        r_qp_p0  <= r_hist_q;
        r_hist_i <= i_in;
        r_hist_q <= q_in;
        r_primed <= 1'b1;
      end
    end
  end

  // Stage 2: register both cross products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pa_p1  <= '0;
      r_pb_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_pa_p1  <= w_pa;
      r_pb_p1  <= w_pb;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // Stage 3: register the difference d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_p2   <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_d_p2   <= cross_diff(r_pa_p1, r_pb_p1);
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Accumulate-and-dump; bypass forces the block to idle so a later 1->0 starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      r_dump_p3     <= '0;
      r_dump_vld_p3 <= 1'b0;
    end else begin
      r_dump_vld_p3 <= 1'b0;
      if (bypass) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_vld_p2) begin
        if (r_cnt == LAST) begin
          r_dump_p3     <= w_sum;
          r_dump_vld_p3 <= 1'b1;
          r_acc         <= '0;
          r_cnt         <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Output register: per-sample result in bypass, otherwise the block dump; value held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_out     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bypass && r_vld_p2) begin
        r_m_out     <= w_d_ext;
        r_out_valid <= 1'b1;
      end else if (r_dump_vld_p3) begin
        r_m_out     <= r_dump_p3;
        r_out_valid <= 1'b1;
      end
    end
  end

endmodule
